// File: rtl/katp91_bus_pkg.sv
// Shared bus definitions for the katp91 CPU and its bus slaves.
//   ADDR_W / DATA_W / RESET_VECTOR : bus geometry and CPU boot address
//   bus_ram_state_e                : bus_ram access FSM states
//   bus_ram_dbg_t                  : bus_ram observation struct (state + bus drive)
package katp91_bus_pkg;

  localparam int          ADDR_W       = 16;
  localparam int          DATA_W       = 8;
  localparam logic [15:0] RESET_VECTOR = 16'h2000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    WRITE    = 2'd2,
    CONFLICT = 2'd3
  } bus_ram_state_e;

  typedef struct packed {
    bus_ram_state_e state;
    logic           drive;
  } bus_ram_dbg_t;

endpackage

// File: rtl/bus_ram_array.sv
// Byte storage for bus_ram: 2**AW x DATA_W.
//   clk, reset           : clock; reset clears only the read output register
//   load_en/addr/data    : preload write, always wins the single write port
//   bus_we/addr/data     : CPU write, dropped when a preload shares the edge
//   rd_en, rd_addr       : synchronous read request
//   rd_data              : registered read byte (one-edge latency)
module bus_ram_array
  import katp91_bus_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              bus_we,
  input  logic [AW-1:0]     bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**AW];

  // Storage is deliberately not reset so preloaded images survive a CPU reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (bus_we) begin
      mem[bus_addr] <= bus_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bus_ram.sv
// CPU-bus RAM slave decoding BASE .. BASE+2**AW-1.
//   clk, reset         : clock, async active-high reset
//   adress_bus         : CPU byte address
//   date_bus           : shared data bus, driven only during a hit read
//   r, w               : level-active read / write strobes
//   load_en/addr/data  : preload port (any state, beats a CPU write)
//   hit                : last sampled access fell in the window
//   bus_error          : sticky, r and w were sampled high together
//   dbg                : FSM state and bus-drive enable for observation
//
// Bus protocol: r and w are levels sampled at posedge clk. A read is accepted
// on the first edge r is seen with an in-window address and returns the byte
// on date_bus after that edge for as long as r stays high (address may change,
// the byte follows one edge later). A write is accepted once, on the first edge
// w is seen in-window; w must drop and rise again for another write. r and w
// together is a protocol error that parks the FSM in CONFLICT.
module bus_ram
  import katp91_bus_pkg::*;
#(
  parameter logic [15:0] BASE = RESET_VECTOR,
  parameter int          AW   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adress_bus,
  inout  wire  [DATA_W-1:0] date_bus,
  input  logic              r,
  input  logic              w,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              hit,
  output logic              bus_error,
  output bus_ram_dbg_t      dbg
);

  // One past the window top, widened so BASE near 16'hFFFF cannot wrap.
  localparam logic [16:0] WIN_END = {1'b0, BASE} + (17'd1 << AW);

  bus_ram_state_e    state, state_n;
  logic              in_window;
  logic [AW-1:0]     offset;
  logic              bus_we;
  logic              rd_en;
  logic              drive;
  logic [DATA_W-1:0] rd_data;

  assign in_window = (adress_bus >= BASE) && ({1'b0, adress_bus} < WIN_END);
  // Only meaningful when in_window is set; truncation happens after the check.
  assign offset    = AW'(adress_bus - BASE);

  always_comb begin
    state_n = state;
    if (r && w) begin
      state_n = CONFLICT;
    end else begin
      case (state)
        IDLE: begin
          if (r && in_window)      state_n = READ;
          else if (w && in_window) state_n = WRITE;
        end
        READ: begin
          if (!r || !in_window) state_n = IDLE;
        end
        WRITE: begin
          if (!w) state_n = IDLE;
        end
        CONFLICT: begin
          if (!r && !w) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A write lands only on the edge that enters WRITE, so a held w never repeats.
  assign bus_we = (state == IDLE) && (state_n == WRITE);
  assign rd_en  = (state_n == READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hit       <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= state_n;
      if (r || w) hit <= in_window;
      if (r && w) bus_error <= 1'b1;
    end
  end

  bus_ram_array #(.AW(AW)) u_array (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .bus_we    (bus_we),
    .bus_addr  (offset),
    .bus_data  (date_bus),
    .rd_en     (rd_en),
    .rd_addr   (offset),
    .rd_data   (rd_data)
  );

  // Gated by the live r so the bus is released the moment the CPU drops it.
  assign drive    = (state == READ) && r;
  assign date_bus = drive ? rd_data : {DATA_W{1'bz}};

  assign dbg.state = state;
  assign dbg.drive = drive;

endmodule

// File: tb/tb_bus_ram.sv
module tb_bus_ram;
  import katp91_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]  adress_bus = 16'h0000;
  logic         r = 1'b0;
  logic         w = 1'b0;
  logic         load_en = 1'b0;
  logic [11:0]  load_addr = 12'h000;
  logic [7:0]   load_data = 8'h00;
  logic         hit;
  logic         bus_error;
  bus_ram_dbg_t dbg;
  wire  [7:0]   date_bus;
  logic         tb_oe = 1'b0;
  logic [7:0]   tb_data = 8'h00;

  assign date_bus = tb_oe ? tb_data : 8'hzz;

  bus_ram #(.BASE(16'h2000), .AW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .adress_bus (adress_bus),
    .date_bus   (date_bus),
    .r          (r),
    .w          (w),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .hit        (hit),
    .bus_error  (bus_error),
    .dbg        (dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after posedge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    cycle();
    load_en = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    adress_bus = a; w = 1'b1; tb_oe = 1'b1; tb_data = d;
    cycle();
    w = 1'b0; tb_oe = 1'b0;
    cycle();
  endtask

  // Issues a read, checks the returned byte, then drops r.
  task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] d);
    adress_bus = a; r = 1'b1;
    exp_q.push_back(d);
    cycle();
    check(tag, {8'h00, date_bus}, {8'h00, exp_q.pop_front()});
    r = 1'b0;
    cycle();
  endtask

  initial begin
    // reset state
    #12;
    check("rst_state", 16'(dbg.state), 16'(IDLE));
    check("rst_hit", {15'd0, hit}, 16'd0);
    check("rst_err", {15'd0, bus_error}, 16'd0);
    check("rst_drive", {15'd0, dbg.drive}, 16'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // preload + one-edge read latency, release on r falling
    preload(12'h000, 8'hA5);
    preload(12'hFFF, 8'h6E);
    adress_bus = 16'h2000; r = 1'b1;
    #1;
    check("rd_no_drive_before_edge", {15'd0, dbg.drive}, 16'd0);
    cycle();
    check("rd_state", 16'(dbg.state), 16'(READ));
    check("rd_drive", {15'd0, dbg.drive}, 16'd1);
    check("rd_data_a5", {8'h00, date_bus}, 16'h00A5);
    check("rd_hit", {15'd0, hit}, 16'd1);
    r = 1'b0;
    #1;
    check("rd_release_on_r", {15'd0, dbg.drive}, 16'd0);
    cycle();
    check("rd_back_idle", 16'(dbg.state), 16'(IDLE));
    check("hit_hold", {15'd0, hit}, 16'd1);

    // held write stores once; later held cycles carry different data
    adress_bus = 16'h2010; w = 1'b1; tb_oe = 1'b1; tb_data = 8'h3C;
    cycle();
    check("wr_state", 16'(dbg.state), 16'(WRITE));
    tb_data = 8'h99;
    cycle();
    cycle();
    check("wr_hold_state", 16'(dbg.state), 16'(WRITE));
    w = 1'b0; tb_oe = 1'b0;
    cycle();
    check("wr_back_idle", 16'(dbg.state), 16'(IDLE));

    // streaming read: address moves while r held, then leaves window
    adress_bus = 16'h2010; r = 1'b1;
    cycle();
    check("wr_readback_3c", {8'h00, date_bus}, 16'h003C);
    adress_bus = 16'h2000;
    cycle();
    check("stream_a5", {8'h00, date_bus}, 16'h00A5);
    adress_bus = 16'h3000;
    cycle();
    check("stream_leave_state", 16'(dbg.state), 16'(IDLE));
    check("stream_leave_drive", {15'd0, dbg.drive}, 16'd0);
    check("stream_leave_hit", {15'd0, hit}, 16'd0);
    r = 1'b0;
    cycle();

    // a second write needs w to drop and rise again
    bus_write(16'h2011, 8'h44);
    bus_write(16'h2011, 8'h55);
    read_check("rewrite_55", 16'h2011, 8'h55);

    // window boundaries
    adress_bus = 16'h1FFF; r = 1'b1;
    cycle();
    check("below_hit", {15'd0, hit}, 16'd0);
    check("below_state", 16'(dbg.state), 16'(IDLE));
    check("below_drive", {15'd0, dbg.drive}, 16'd0);
    r = 1'b0;
    cycle();
    read_check("top_6e", 16'h2FFF, 8'h6E);
    check("top_hit", {15'd0, hit}, 16'd1);
    adress_bus = 16'h3000; r = 1'b1;
    cycle();
    check("above_hit", {15'd0, hit}, 16'd0);
    check("above_drive", {15'd0, dbg.drive}, 16'd0);
    r = 1'b0;
    adress_bus = 16'h3000; w = 1'b1; tb_oe = 1'b1; tb_data = 8'h12;
    cycle();
    check("above_wr_state", 16'(dbg.state), 16'(IDLE));
    w = 1'b0; tb_oe = 1'b0;
    cycle();
    read_check("no_wrap_a5", 16'h2000, 8'hA5);

    // preload beats a same-edge bus write
    load_en = 1'b1; load_addr = 12'h005; load_data = 8'h11;
    adress_bus = 16'h2005; w = 1'b1; tb_oe = 1'b1; tb_data = 8'h22;
    cycle();
    load_en = 1'b0; w = 1'b0; tb_oe = 1'b0;
    cycle();
    read_check("load_wins_11", 16'h2005, 8'h11);
    check("load_wins_no_err", {15'd0, bus_error}, 16'd0);

    // r and w together
    adress_bus = 16'h2010; r = 1'b1; w = 1'b1; tb_oe = 1'b1; tb_data = 8'h66;
    cycle();
    check("conf_state", 16'(dbg.state), 16'(CONFLICT));
    check("conf_err", {15'd0, bus_error}, 16'd1);
    check("conf_drive", {15'd0, dbg.drive}, 16'd0);
    r = 1'b0;
    cycle();
    check("conf_hold", 16'(dbg.state), 16'(CONFLICT));
    w = 1'b0; tb_oe = 1'b0;
    cycle();
    check("conf_exit", 16'(dbg.state), 16'(IDLE));
    check("conf_err_sticky", {15'd0, bus_error}, 16'd1);
    read_check("conf_no_store", 16'h2010, 8'h3C);
    check("conf_err_still", {15'd0, bus_error}, 16'd1);

    // reset in the middle of a read
    adress_bus = 16'h2000; r = 1'b1;
    cycle();
    check("mid_rd_drive", {15'd0, dbg.drive}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_drive", {15'd0, dbg.drive}, 16'd0);
    check("rst_mid_state", 16'(dbg.state), 16'(IDLE));
    check("rst_mid_hit", {15'd0, hit}, 16'd0);
    check("rst_mid_err", {15'd0, bus_error}, 16'd0);
    r = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    read_check("after_rst_a5", 16'h2000, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_ram.md
BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 SHALL have parameter BASE, default 16'h2000, first bus address decoded by the block (CPU reset vector).
REQ-002 SHALL have parameter AW, default 12, log2 of byte capacity; decoded window is BASE .. BASE+2**AW-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port adress_bus  input  16  CPU byte address.
REQ-006 SHALL have port date_bus  inout  8  shared data bus; driven only during a hit read, else high-Z.
REQ-007 SHALL have port r  input  1  CPU read strobe, level-active.
REQ-008 SHALL have port w  input  1  CPU write strobe, level-active.
REQ-009 SHALL have port load_en  input  1  bench/boot preload write enable.
REQ-010 SHALL have port load_addr  input  AW  preload offset within the window.
REQ-011 SHALL have port load_data  input  8  preload byte.
REQ-012 SHALL have port hit  output  1  registered: last sampled access fell in the window.
REQ-013 SHALL have port bus_error  output  1  sticky flag: r and w sampled high together.

Function
REQ-014 SHALL run FSM states IDLE, READ, WRITE, CONFLICT, evaluated at each posedge clk.
REQ-015 IDLE: r=1,w=0,in-window -> READ; w=1,r=0,in-window -> WRITE; r=1,w=1 -> CONFLICT; otherwise stay IDLE.
REQ-016 Out-of-window r or w SHALL leave FSM in IDLE, clear hit, never drive date_bus, never write storage.
REQ-017 READ: at the entry posedge, register mem[adress_bus-BASE] into the output byte; read latency is exactly one posedge.
REQ-018 READ: while r stays high, re-register the byte from the current address on every posedge; leave the window -> IDLE, release bus.
REQ-019 date_bus SHALL be driven only while state==READ AND r==1, gated combinationally by r, so it goes high-Z the instant r falls.
REQ-020 READ: r sampled low -> IDLE.
REQ-021 WRITE: store date_bus to mem[adress_bus-BASE] exactly once, at the entry posedge; hold in WRITE until w is sampled low, then IDLE.
REQ-022 A second write requires w to deassert and reassert; a held w is never a repeated write.
REQ-023 r=1 and w=1 sampled together, in any state, SHALL go to CONFLICT, set bus_error, release bus, suppress storage write.
REQ-024 CONFLICT SHALL hold until r=0 and w=0 are sampled together, then IDLE; bus_error clears only on reset.
REQ-025 load_en=1 SHALL write load_data to mem[load_addr] at that posedge in any FSM state.
REQ-026 Same-posedge load_en and bus write to the same offset: load wins, bus write dropped, bus_error unaffected.
REQ-027 Offset arithmetic SHALL be 16-bit unsigned, truncated to AW bits after the window check; window-top address maps to offset 2**AW-1.
REQ-028 hit SHALL update on every posedge where r or w is high; hold its value when both are low.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, hit=0, bus_error=0, output byte 0, date_bus high-Z, independent of clk.
REQ-030 Reset during READ or WRITE SHALL abort the access; an in-progress WRITE whose entry posedge already occurred keeps its stored byte.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 Package katp91_bus_pkg SHALL hold ADDR_W=16, DATA_W=8, RESET_VECTOR=16'h2000 and the bus_ram state enum; the CPU shares the first three.
REQ-033 Storage SHALL be sub-module bus_ram_array: 2**AW x 8, one write port with load-priority mux, one synchronous read port.

Verification
REQ-034 Preload 0xA5 at offset 0; r=1, addr 0x2000 -> date_bus 0xA5 one posedge later; high-Z as soon as r=0.
REQ-035 w=1, addr 0x2010, date_bus 0x3C held 3 cycles; then read 0x2010 -> 0x3C, exactly one write performed.
REQ-036 r=1, addr 0x1FFF then 0x3000 (AW=12) -> hit=0, date_bus high-Z, storage unchanged.
REQ-037 r=1 and w=1 together -> bus_error=1, no drive; drop both -> IDLE, bus_error stays 1 until reset.
REQ-038 Assert reset mid-READ -> date_bus high-Z immediately, state IDLE; previously preloaded 0xA5 still reads back after reset.
REQ-039 Same posedge: load_en to offset 5 with 0x11 and bus write to 0x2005 with 0x22 -> readback 0x11.
